// File: rtl/m5_pkg.sv
// Shared types for the AR sample queue.
// Compile-time constants and types only; no logic.
// Not applicable: nothing to back-pressure.
package m5_pkg;
  localparam int unsigned AR_Q_DEPTH = 16;

  // One sampled AR handshake: address plus the observed handshake bits.
  typedef struct packed {
    logic [33:0] araddr;
    logic        arvalid;
    logic        arready;
  } queue_struct_t;
endpackage

// File: rtl/mig_params.sv
// Migration-tracker shared parameters.
// Compile-time constants only; no logic.
// Not applicable: nothing to back-pressure.
package mig_params;
  // Monitored migration window: 16 MB.
  localparam int unsigned MIG_REGION_SIZE = 32'd16777216;
endpackage

// File: rtl/m5_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Push visible at head one cycle later; pop advances head next cycle.
// Push while full is accepted only together with a pop; otherwise ignored.
module m5_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     pop_vld_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_en, push_en;

  assign pop_en  = pop_i & (cnt_q != '0);
  assign push_en = push_i & ((cnt_q != CW'(DEPTH)) | pop_en);

  // Next-state for pointers and count; a same-cycle push and pop keeps the count.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_vld_o   = (cnt_q != '0);
  assign pop_dat_o   = pop_vld_o ? mem_q[rd_ptr_q] : '0;
  assign occupancy_o = cnt_q;
  assign full_o      = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/m5_ar_sample_queue.sv
// Samples AR handshakes in the migration window into a FWFT queue.
// Handshake in cycle N appears at q_out in cycle N+1.
// Never stalls the AR channel; records arriving to a full queue are dropped and counted.
module m5_ar_sample_queue
  import m5_pkg::*;
#(
  parameter int          DEPTH        = m5_pkg::AR_Q_DEPTH,
  parameter int          SAMPLE_SHIFT = 0,
  parameter int unsigned REGION_SIZE  = mig_params::MIG_REGION_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [33:0]              ar_araddr,
  input  logic                     ar_arvalid,
  input  logic                     ar_arready,
  input  logic                     region_en,
  input  logic [33:0]              region_base,
  output queue_struct_t            q_out,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic [31:0]              drop_cnt
);
  localparam int R = $clog2(REGION_SIZE);

  logic          hs, qual, candidate, pop, push, drop;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  queue_struct_t rec;
  logic [35:0]   head_dat;
  logic          unused_base_lo;

  assign hs   = ar_arvalid & ar_arready;
  assign qual = hs & (~region_en | (ar_araddr[33:R] == region_base[33:R]));
  // Address bits below the window granularity play no part in the match.
  assign unused_base_lo = ^region_base[R-1:0];

  // Keep 1 of every 2^SAMPLE_SHIFT qualifying handshakes; drops do not disturb the phase.
  if (SAMPLE_SHIFT == 0) begin : g_nodec
    assign candidate = qual;
  end else begin : g_dec
    logic [SAMPLE_SHIFT-1:0] dec_q, dec_d;
    assign dec_d     = qual ? dec_q + SAMPLE_SHIFT'(1) : dec_q;
    assign candidate = qual & (dec_q == '0);
    // Decimation phase counter.
    always_ff @(posedge clk) begin
      if (reset) dec_q <= '0;
      else       dec_q <= dec_d;
    end
  end

  assign pop  = q_valid & q_ready;
  assign push = candidate & (~full | pop);
  assign drop = candidate & full & ~pop;

  assign rec.araddr  = ar_araddr;
  assign rec.arvalid = 1'b1;
  assign rec.arready = 1'b1;

  m5_sync_fifo #(
    .WIDTH ($bits(queue_struct_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_dat_i  (rec),
    .pop_i       (pop),
    .pop_dat_o   (head_dat),
    .pop_vld_o   (q_valid),
    .occupancy_o (occupancy),
    .full_o      (full)
  );

  assign q_out = queue_struct_t'(head_dat);

  assign drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 32'd1 : drop_cnt_q;

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_m5_ar_sample_queue.sv
// Directed bench for m5_ar_sample_queue: pass-through, filter, overflow, decimation, reset.
// Two instances share stimulus: u_dut (no decimation) and u_dec (keep 1 of 4).
// Outputs are sampled 1 ns after the rising edge.
module tb_m5_ar_sample_queue;
  import m5_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] ar_araddr;
  logic        ar_arvalid, ar_arready, region_en, q_ready;
  logic [33:0] region_base;

  queue_struct_t q_out_a, q_out_b;
  logic          q_valid_a, q_valid_b, full_a, full_b;
  logic [4:0]    occ_a, occ_b;
  logic [31:0]   drop_a, drop_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m5_ar_sample_queue #(.DEPTH(16), .SAMPLE_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .ar_araddr(ar_araddr), .ar_arvalid(ar_arvalid),
    .ar_arready(ar_arready), .region_en(region_en), .region_base(region_base),
    .q_out(q_out_a), .q_valid(q_valid_a), .q_ready(q_ready),
    .occupancy(occ_a), .full(full_a), .drop_cnt(drop_a)
  );

  m5_ar_sample_queue #(.DEPTH(16), .SAMPLE_SHIFT(2)) u_dec (
    .clk(clk), .reset(reset), .ar_araddr(ar_araddr), .ar_arvalid(ar_arvalid),
    .ar_arready(ar_arready), .region_en(region_en), .region_base(region_base),
    .q_out(q_out_b), .q_valid(q_valid_b), .q_ready(q_ready),
    .occupancy(occ_b), .full(full_b), .drop_cnt(drop_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] rec(input logic [33:0] a);
    return {a, 2'b11};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hs(input logic [33:0] a);
    ar_araddr  = a;
    ar_arvalid = 1'b1;
    ar_arready = 1'b1;
    cyc();
  endtask

  function automatic logic [33:0] ov_addr(input int i);
    return 34'h0_0000_2000 + 34'(i) * 34'h40;
  endfunction

  function automatic logic [33:0] dec_addr(input int i);
    return 34'h0_0000_4000 + 34'(i) * 34'h40;
  endfunction

  initial begin
    reset = 1'b1; ar_araddr = '0; ar_arvalid = 1'b0; ar_arready = 1'b0;
    region_en = 1'b0; region_base = '0; q_ready = 1'b0;
    #1; cyc(); cyc();
    // Reset state
    chk("rst_q_valid", q_valid_a, 0);
    chk("rst_full",    full_a,    0);
    chk("rst_occ",     occ_a,     0);
    chk("rst_q_out",   q_out_a,   0);
    chk("rst_drop",    drop_a,    0);
    reset = 1'b0;
    cyc();

    // Basic pass-through, consumer always ready
    q_ready = 1'b1;
    hs(34'h0_0000_1000);
    chk("pt_vld0", q_valid_a, 1);
    chk("pt_rec0", q_out_a, rec(34'h0_0000_1000));
    hs(34'h3_FFFF_FFC0);
    chk("pt_rec1", q_out_a, rec(34'h3_FFFF_FFC0));
    chk("pt_occ1", occ_a, 1);
    ar_arvalid = 1'b0; cyc();
    chk("pt_empty", q_valid_a, 0);
    chk("pt_drop",  drop_a, 0);

    // Region filter: 16 MB window at 0x0_0100_0000
    q_ready = 1'b0; region_en = 1'b1; region_base = 34'h0_0100_0000;
    hs(34'h0_0100_0040);
    hs(34'h0_0200_0000);
    hs(34'h0_01FF_FFC0);
    ar_arvalid = 1'b0; cyc();
    chk("rf_occ", occ_a, 2);
    q_ready = 1'b1;
    chk("rf_rec0", q_out_a, rec(34'h0_0100_0040));
    cyc();
    chk("rf_rec1", q_out_a, rec(34'h0_01FF_FFC0));
    cyc();
    chk("rf_empty", q_valid_a, 0);

    // Valid without ready is not a handshake
    region_en = 1'b0; q_ready = 1'b0;
    ar_araddr = 34'h0_0000_3000; ar_arvalid = 1'b1; ar_arready = 1'b0;
    repeat (5) cyc();
    ar_arvalid = 1'b0; cyc();
    chk("nh_vld", q_valid_a, 0);
    chk("nh_occ", occ_a, 0);

    // Overflow: 20 back-to-back handshakes into a 16-deep queue
    for (int i = 0; i < 20; i++) begin
      hs(ov_addr(i));
      if (i == 14) chk("ov_notfull15", full_a, 0);
      if (i == 15) chk("ov_full16", full_a, 1);
    end
    ar_arvalid = 1'b0; cyc();
    chk("ov_drop", drop_a, 4);
    chk("ov_occ",  occ_a, 16);

    // Full with simultaneous pop: no drop, new record lands at the tail
    q_ready = 1'b1;
    hs(34'h0_0000_ABC0);
    ar_arvalid = 1'b0;
    chk("fp_drop", drop_a, 4);
    chk("fp_occ",  occ_a, 16);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fp_drain%0d", i), q_out_a, rec(ov_addr(i)));
      cyc();
    end
    chk("fp_tail", q_out_a, rec(34'h0_0000_ABC0));
    cyc();
    chk("fp_empty", q_valid_a, 0);

    // Decimation by 4 from a clean start
    q_ready = 1'b0; reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 8; i++) hs(dec_addr(i));
    ar_arvalid = 1'b0; cyc();
    chk("dc_occ", occ_b, 2);
    chk("dc_head", q_out_b, rec(dec_addr(0)));
    hs(dec_addr(8));
    ar_arvalid = 1'b0;
    chk("dc_occ3", occ_b, 3);
    chk("dc_drop", drop_b, 0);
    chk("dc_occ_full_rate", occ_a, 9);
    q_ready = 1'b1; cyc();
    chk("dc_rec1", q_out_b, rec(dec_addr(4)));
    q_ready = 1'b0;

    // Reset mid-stream with a handshake in flight
    reset = 1'b1;
    ar_araddr = 34'h0_0000_5000; ar_arvalid = 1'b1; ar_arready = 1'b1;
    cyc();
    chk("mr_vld",   q_valid_b, 0);
    chk("mr_occ",   occ_b, 0);
    chk("mr_drop",  drop_b, 0);
    chk("mr_q_out", q_out_b, 0);
    chk("mr_occ_a", occ_a, 0);
    reset = 1'b0; ar_arvalid = 1'b0; cyc();
    chk("mr_discard", occ_b, 0);
    hs(34'h0_0000_6000);
    ar_arvalid = 1'b0;
    chk("mr_restart_occ", occ_b, 1);
    chk("mr_restart_rec", q_out_b, rec(34'h0_0000_6000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/m5_ar_sample_queue.md
# m5_ar_sample_queue

- Taps the AXI read-address (AR) channel between the CXL host interface and device memory.
- On each completed AR handshake inside the monitored migration region, it forms a `queue_struct_t` record, optionally decimates, and buffers it in a first-word-fall-through FIFO.
- It sits upstream of the page-hotness/migration tracker, which drains records through a valid/ready port.
- It observes only and never back-pressures the AR channel; on overflow it drops records and counts them.

## Interface

Parameters:
- `DEPTH`, 16 — FIFO entries; power of two, at least 2.
- `SAMPLE_SHIFT`, 0 — keep 1 of every 2^SAMPLE_SHIFT qualifying handshakes; range 0..8.
- `REGION_SIZE`, `mig_params::MIG_REGION_SIZE` — monitored window size in bytes; power of two.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `ar_araddr` in 34 — tapped AR address.
- `ar_arvalid` in 1 — tapped AR valid.
- `ar_arready` in 1 — tapped AR ready.
- `region_en` in 1 — 1: filter by region; 0: accept all handshakes.
- `region_base` in 34 — window base; low log2(REGION_SIZE) bits ignored.
- `q_out` out 36 — head record, type `queue_struct_t`.
- `q_valid` out 1 — FIFO non-empty.
- `q_ready` in 1 — consumer accepts the head.
- `occupancy` out $clog2(DEPTH)+1 — current entry count.
- `full` out 1 — occupancy == DEPTH.
- `drop_cnt` out 32 — records lost to full FIFO; saturating.

## Operation

- **Handshake:** `hs = ar_arvalid & ar_arready`.
- **Qualify:** `qual = hs & (!region_en | (ar_araddr[33:R] == region_base[33:R]))`, where R = log2(REGION_SIZE).
- **Decimation counter:**
  - SAMPLE_SHIFT bits wide; increments on each `qual` and wraps.
  - A record is candidate when `qual` and counter == 0 before the increment.
  - With SAMPLE_SHIFT = 0, every `qual` is a candidate.
- **Record fields:** `araddr = ar_araddr`, `arvalid = 1`, `arready = 1`.
- **Pop:** `q_valid & q_ready`.
- **Push:**
  - Candidate is pushed if `!full`, or if `full` and a pop occurs in the same cycle.
  - Otherwise it is dropped and `drop_cnt` increments, holding at 0xFFFF_FFFF.
  - A drop does not affect the decimation counter.
- **Simultaneous push and pop:** occupancy is unchanged. With DEPTH = 1-occupancy edge cases, the head advances correctly; the pushed entry is never lost.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `occupancy`.
- **`region_en` and `region_base` changes** take effect on the next cycle's qualification.
- **Reset:**
  - Clears pointers, occupancy, decimation counter and `drop_cnt`.
  - Outputs after reset: `q_valid = 0`, `full = 0`, `occupancy = 0`, `q_out = 0`, `drop_cnt = 0`.
  - Any in-flight handshake during the reset cycle is discarded and not counted.

## Timing

- Push latency: handshake in cycle N → entry visible, `q_valid = 1` and `q_out` valid in cycle N+1.
- `q_out` is stable while `q_valid & !q_ready`.
- After a pop in cycle N, the next head (if any) is presented in cycle N+1.
- `occupancy`, `full` and `drop_cnt` are registered and reflect cycle N events in cycle N+1.
- Full throughput: one push and one pop per cycle.
- No combinational path from `q_ready` to `q_valid` or `q_out`. The only combinational dependence is push gating on `q_ready` when full.

## Structure

- `m5_pkg` owns `queue_struct_t` (34-bit `araddr`, `arvalid`, `arready`; 36 bits).
- Add `m5_pkg::AR_Q_DEPTH = 16` as the shared default.
- `mig_params` supplies `MIG_REGION_SIZE`.
- One sub-module: `m5_sync_fifo` — generic FWFT FIFO, parameters WIDTH and DEPTH, with push/pop/occupancy.
- The top level holds filter, decimation and drop logic.

## Test plan

- **Basic pass-through:** `region_en = 0`, SAMPLE_SHIFT = 0; handshakes at 0x0_0000_1000 and 0x3_FFFF_FFC0 on consecutive cycles, `q_ready = 1` → two records in order, each one cycle later; `arvalid = arready = 1`; `drop_cnt = 0`.
- **Region filter:** `region_en = 1`, `region_base = 0x0_0100_0000`, REGION_SIZE = 16 MB; addresses 0x0_0100_0040 (kept), 0x0_0200_0000 (rejected), 0x0_01FF_FFC0 (kept) → exactly 2 records.
- **Non-handshake ignored:** `ar_arvalid = 1`, `ar_arready = 0` for 5 cycles → no records.
- **Overflow:** `q_ready = 0`, 20 back-to-back handshakes, DEPTH = 16 → `full = 1` after the 16th; `drop_cnt = 4`; the drained sequence equals the first 16 addresses.
- **Full with simultaneous pop:** FIFO full, handshake and pop in the same cycle → no drop; occupancy stays 16; the new record appears last.
- **Decimation and reset:** SAMPLE_SHIFT = 2, 8 qualifying handshakes → records for the 1st and 5th only. Assert `reset` mid-stream with 3 entries queued → next cycle `q_valid = 0`, `occupancy = 0`, `drop_cnt = 0`, counter restarts at 0.
